// File: rtl/seg7_scan_driver_if.sv
// Purpose: bundles the value/control inputs and segment/digit outputs of the
//          seven-segment scan driver; Clk/nRst remain plain ports.
// Ports:   Value/Load/Blank_lz/Blink toward the driver, Seg/Dig back out.
interface seg7_scan_driver_if #(
   parameter int NB_DIGITS = 4
);
   logic [4*NB_DIGITS-1:0] Value;
   logic                   Load;
   logic                   Blank_lz;
   logic                   Blink;
   logic [6:0]             Seg;
   logic [NB_DIGITS-1:0]   Dig;

   modport master (
      output Value, Load, Blank_lz, Blink,
      input  Seg, Dig
   );

   modport slave (
      input  Value, Load, Blank_lz, Blink,
      output Seg, Dig
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Purpose:  time-multiplexed BCD seven-segment driver with leading-zero blanking and blink.
// Latency:  Seg/Dig registered; one cycle from any internal state change to the outputs.
// Backpres: none; Load is a fire-and-forget strobe, the shadow register is always ready.
// Ports:    Clk, nRst (async active-low); bus.slave: Value (4 bits per digit), Load,
//           Blank_lz, Blink in; Seg (a..g, Seg[6]=a) and Dig (one-hot select) out.
module seg7_scan_driver #(
   parameter int NB_DIGITS       = 4,
   parameter int SCAN_DIV        = 50000,
   parameter int BLINK_DIV       = 32,
   parameter int OUTPUT_POLARITY = 0,
   parameter int DIGIT_POLARITY  = 0
) (
   input  logic                Clk,
   input  logic                nRst,
   seg7_scan_driver_if.slave   bus
);

   localparam int PRESC_W = $clog2(SCAN_DIV);
   localparam int IDX_W   = (NB_DIGITS > 1) ? $clog2(NB_DIGITS) : 1;
   localparam int FRM_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NB_DIGITS - 1);
   localparam logic [FRM_W-1:0]   FRM_LAST   = FRM_W'(BLINK_DIV - 1);

   // XOR masks turning active-high internal values into pad levels; they are
   // also the "all off" / "none selected" levels.
   localparam logic [6:0] SEG_XOR = (OUTPUT_POLARITY != 0) ? 7'h00 : 7'h7F;
   localparam logic [NB_DIGITS-1:0] DIG_XOR =
      (DIGIT_POLARITY != 0) ? {NB_DIGITS{1'b0}} : {NB_DIGITS{1'b1}};

   logic [4*NB_DIGITS-1:0] shadow_q, shadow_d;
   logic [PRESC_W-1:0]     presc_q,  presc_d;
   logic [IDX_W-1:0]       idx_q,    idx_d;
   logic [FRM_W-1:0]       frm_q,    frm_d;
   logic                   phase_q,  phase_d;
   logic [6:0]             seg_q,    seg_d;
   logic [NB_DIGITS-1:0]   dig_q,    dig_d;

   logic                   tick;
   logic                   last_idx;
   logic                   frame_end;
   logic [3:0]             nib;
   logic [NB_DIGITS-1:0]   dig_oh;
   logic                   upper_nz;
   logic                   lz_blank;
   logic                   blink_blank;
   logic                   show;

   function automatic logic [6:0] decode(input logic [3:0] n);
      logic [6:0] p;
      case (n)
         4'd0:    p = 7'b1111110;
         4'd1:    p = 7'b0110000;
         4'd2:    p = 7'b1101101;
         4'd3:    p = 7'b1111001;
         4'd4:    p = 7'b0110011;
         4'd5:    p = 7'b1011011;
         4'd6:    p = 7'b1011111;
         4'd7:    p = 7'b1110000;
         4'd8:    p = 7'b1111111;
         4'd9:    p = 7'b1111011;
         default: p = 7'b0110111;   // non-BCD nibble shows 'H'
      endcase
      return p;
   endfunction

   always_comb begin
      // Scan timing
      tick      = (presc_q == PRESC_LAST);
      last_idx  = (idx_q == IDX_LAST);
      frame_end = tick && last_idx;

      presc_d = tick ? '0 : presc_q + 1'b1;

      idx_d = idx_q;
      if (tick) begin
         idx_d = last_idx ? '0 : idx_q + 1'b1;
      end

      frm_d   = frm_q;
      phase_d = phase_q;
      if (frame_end) begin
         if (frm_q == FRM_LAST) begin
            frm_d   = '0;
            phase_d = ~phase_q;
         end else begin
            frm_d = frm_q + 1'b1;
         end
      end

      shadow_d = bus.Load ? bus.Value : shadow_q;

      // Display path works on the current (pre-edge) index and shadow, so a
      // Load landing on a tick shows up together with the new index.
      nib      = 4'd0;
      dig_oh   = '0;
      upper_nz = 1'b0;
      for (int i = 0; i < NB_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib       = shadow_q[i*4 +: 4];
            dig_oh[i] = 1'b1;
         end
         // Any non-zero nibble at or above the current digit keeps it lit.
         if ((IDX_W'(i) >= idx_q) && (shadow_q[i*4 +: 4] != 4'd0)) begin
            upper_nz = 1'b1;
         end
      end

      lz_blank    = bus.Blank_lz && (idx_q != '0) && !upper_nz;
      blink_blank = bus.Blink && phase_q;
      show        = !lz_blank && !blink_blank;

      seg_d = (show ? decode(nib) : 7'h00) ^ SEG_XOR;
      dig_d = (show ? dig_oh : {NB_DIGITS{1'b0}}) ^ DIG_XOR;
   end

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         shadow_q <= '0;
         presc_q  <= '0;
         idx_q    <= '0;
         frm_q    <= '0;
         phase_q  <= 1'b0;
         seg_q    <= SEG_XOR;
         dig_q    <= DIG_XOR;
      end else begin
         shadow_q <= shadow_d;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         frm_q    <= frm_d;
         phase_q  <= phase_d;
         seg_q    <= seg_d;
         dig_q    <= dig_d;
      end
   end

   assign bus.Seg = seg_q;
   assign bus.Dig = dig_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

   logic Clk  = 1'b0;
   logic nRst = 1'b0;
   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_errors = 0;
   int k        = 0;   // rising edges since the last reset release

   seg7_scan_driver_if #(.NB_DIGITS(4)) bus   ();
   seg7_scan_driver_if #(.NB_DIGITS(4)) bus_p ();
   seg7_scan_driver_if #(.NB_DIGITS(1)) bus_1 ();

   assign bus_p.Value    = bus.Value;
   assign bus_p.Load     = bus.Load;
   assign bus_p.Blank_lz = bus.Blank_lz;
   assign bus_p.Blink    = bus.Blink;
   assign bus_1.Value    = bus.Value[3:0];
   assign bus_1.Load     = bus.Load;
   assign bus_1.Blank_lz = bus.Blank_lz;
   assign bus_1.Blink    = bus.Blink;

   seg7_scan_driver #(
      .NB_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2),
      .OUTPUT_POLARITY(0), .DIGIT_POLARITY(0)
   ) u_dut (.Clk(Clk), .nRst(nRst), .bus(bus));

   seg7_scan_driver #(
      .NB_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2),
      .OUTPUT_POLARITY(1), .DIGIT_POLARITY(1)
   ) u_dut_p (.Clk(Clk), .nRst(nRst), .bus(bus_p));

   seg7_scan_driver #(
      .NB_DIGITS(1), .SCAN_DIV(2), .BLINK_DIV(1),
      .OUTPUT_POLARITY(0), .DIGIT_POLARITY(0)
   ) u_dut_1 (.Clk(Clk), .nRst(nRst), .bus(bus_1));

   // Expected pad levels (active-low) for 0x1234, indexed by digit.
   logic [6:0] seg_1234 [4] = '{7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
   // 0x0070 with leading-zero blanking: digits 3,2 dark, '7', '0'.
   logic [6:0] seg_lz70 [4] = '{7'b0000001, 7'b0001111, 7'b1111111, 7'b1111111};
   logic [3:0] dig_lz70 [4] = '{4'b1110, 4'b1101, 4'b1111, 4'b1111};
   logic [3:0] dig_on   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s (k=%0d): got %0b, expected %0b", tag, k, got, exp);
      end
   endtask

   // Advance to the falling edge after rising edge number 'target'.
   task automatic adv(input int target);
      while (k < target) begin
         @(negedge Clk);
         k++;
      end
   endtask

   // Digit index shown at sample point k (SCAN_DIV=4, NB_DIGITS=4).
   function automatic int dgt(input int kk);
      return ((kk - 1) / 4) % 4;
   endfunction

   initial begin
      bus.Value    = '0;
      bus.Load     = 1'b0;
      bus.Blank_lz = 1'b0;
      bus.Blink    = 1'b0;
      nRst         = 1'b0;

      // Reset state
      repeat (3) @(negedge Clk);
      chk("rst_seg",   bus.Seg,   7'b1111111);
      chk("rst_dig",   bus.Dig,   4'b1111);
      chk("rst_seg_p", bus_p.Seg, 7'b0000000);
      chk("rst_dig_p", bus_p.Dig, 4'b0000);
      chk("rst_seg_1", bus_1.Seg, 7'b1111111);
      chk("rst_dig_1", bus_1.Dig, 1'b1);

      nRst = 1'b1;
      k    = 0;

      // First edge after release: digit 0 of zero shadow
      adv(1);
      chk("first_seg",   bus.Seg,   7'b0000001);
      chk("first_dig",   bus.Dig,   4'b1110);
      chk("first_seg_p", bus_p.Seg, 7'b1111110);
      chk("first_dig_p", bus_p.Dig, 4'b0001);
      chk("first_seg_1", bus_1.Seg, 7'b0000001);
      chk("first_dig_1", bus_1.Dig, 1'b0);

      // 0x1234 scan
      bus.Value = 16'h1234;
      bus.Load  = 1'b1;
      adv(2);
      bus.Load  = 1'b0;
      for (int kk = 3; kk <= 18; kk++) begin
         adv(kk);
         chk("scan1234_seg", bus.Seg, seg_1234[dgt(k)]);
         chk("scan1234_dig", bus.Dig, dig_on[dgt(k)]);
      end
      chk("scan1234_seg_p", bus_p.Seg, 7'b0110011);
      chk("scan1234_dig_p", bus_p.Dig, 4'b0001);

      // Blink disabled inside a phase-1 window: still shown
      adv(40);
      chk("noblink_seg", bus.Seg, seg_1234[1]);
      chk("noblink_dig", bus.Dig, dig_on[1]);

      // Blink enabled: shown up to k=96, dark 97..128, shown from 129
      adv(64);
      bus.Blink = 1'b1;
      adv(96);
      chk("blink_pre_seg", bus.Seg, seg_1234[3]);
      chk("blink_pre_dig", bus.Dig, dig_on[3]);
      adv(97);
      chk("blink_on_seg", bus.Seg, 7'b1111111);
      chk("blink_on_dig", bus.Dig, 4'b1111);
      adv(110);
      chk("blink_mid_dig", bus.Dig, 4'b1111);
      adv(128);
      chk("blink_end_seg", bus.Seg, 7'b1111111);
      chk("blink_end_dig", bus.Dig, 4'b1111);
      adv(129);
      chk("blink_post_seg", bus.Seg, seg_1234[0]);
      chk("blink_post_dig", bus.Dig, dig_on[0]);
      bus.Blink = 1'b0;

      // Leading-zero blanking with 0x0070
      adv(130);
      bus.Value    = 16'h0070;
      bus.Blank_lz = 1'b1;
      bus.Load     = 1'b1;
      adv(131);
      bus.Load     = 1'b0;
      for (int kk = 132; kk <= 147; kk++) begin
         adv(kk);
         chk("lz70_seg", bus.Seg, seg_lz70[dgt(k)]);
         chk("lz70_dig", bus.Dig, dig_lz70[dgt(k)]);
      end
      bus.Blank_lz = 1'b0;
      adv(153);
      chk("nolz_d2_seg", bus.Seg, 7'b0000001);
      chk("nolz_d2_dig", bus.Dig, 4'b1011);
      adv(157);
      chk("nolz_d3_seg", bus.Seg, 7'b0000001);
      chk("nolz_d3_dig", bus.Dig, 4'b0111);

      // 0x0A00 with blanking: digit 3 dark, 'H' on digit 2, inner zero lit
      adv(158);
      bus.Value    = 16'h0A00;
      bus.Blank_lz = 1'b1;
      bus.Load     = 1'b1;
      adv(159);
      bus.Load     = 1'b0;
      adv(160);
      chk("a00_d3_seg",   bus.Seg,   7'b1111111);
      chk("a00_d3_dig",   bus.Dig,   4'b1111);
      chk("a00_d3_seg_p", bus_p.Seg, 7'b0000000);
      chk("a00_d3_dig_p", bus_p.Dig, 4'b0000);
      adv(161);
      chk("a00_d0_seg", bus.Seg, 7'b0000001);
      chk("a00_d0_dig", bus.Dig, 4'b1110);
      adv(165);
      chk("a00_d1_seg", bus.Seg, 7'b0000001);
      chk("a00_d1_dig", bus.Dig, 4'b1101);
      adv(169);
      chk("h_seg",   bus.Seg,   7'b1001000);
      chk("h_dig",   bus.Dig,   4'b1011);
      chk("h_seg_p", bus_p.Seg, 7'b0110111);
      chk("h_dig_p", bus_p.Dig, 4'b0100);

      // Load on the tick edge (edge 172): old data/index there, new both after
      adv(171);
      bus.Value    = 16'h5678;
      bus.Blank_lz = 1'b0;
      bus.Load     = 1'b1;
      adv(172);
      bus.Load     = 1'b0;
      chk("ldtick_old_seg", bus.Seg, 7'b1001000);
      chk("ldtick_old_dig", bus.Dig, 4'b1011);
      adv(173);
      chk("ldtick_new_seg", bus.Seg, 7'b0100100);
      chk("ldtick_new_dig", bus.Dig, 4'b0111);

      // Reset mid-frame and mid-blink: outputs drop without waiting for a clock
      adv(174);
      nRst      = 1'b0;
      bus.Blink = 1'b1;
      #1;
      chk("arst_seg",   bus.Seg,   7'b1111111);
      chk("arst_dig",   bus.Dig,   4'b1111);
      chk("arst_seg_p", bus_p.Seg, 7'b0000000);
      chk("arst_dig_p", bus_p.Dig, 4'b0000);
      chk("arst_seg_1", bus_1.Seg, 7'b1111111);
      repeat (2) @(negedge Clk);
      chk("arst_hold_seg", bus.Seg, 7'b1111111);
      chk("arst_hold_dig", bus.Dig, 4'b1111);
      nRst = 1'b1;
      k    = 0;

      // After release: zero shadow, blink phase restarted at 0
      adv(1);
      chk("rel_seg",   bus.Seg,   7'b0000001);
      chk("rel_dig",   bus.Dig,   4'b1110);
      chk("rel_seg_1", bus_1.Seg, 7'b0000001);
      chk("rel_dig_1", bus_1.Dig, 1'b0);
      adv(2);
      chk("one_k2_dig", bus_1.Dig, 1'b0);
      adv(3);
      chk("one_k3_seg", bus_1.Seg, 7'b1111111);
      chk("one_k3_dig", bus_1.Dig, 1'b1);
      chk("rel_k3_dig", bus.Dig,   4'b1110);
      adv(5);
      chk("one_k5_dig", bus_1.Dig, 1'b0);
      chk("rel_k5_dig", bus.Dig,   4'b1101);
      adv(32);
      chk("rel_k32_seg", bus.Seg, 7'b0000001);
      chk("rel_k32_dig", bus.Dig, 4'b0111);
      adv(33);
      chk("rel_k33_seg", bus.Seg, 7'b1111111);
      chk("rel_k33_dig", bus.Dig, 4'b1111);
      bus.Blink = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NB_DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot (legal >= 2).
REQ-003 SHALL have parameter BLINK_DIV, default 32, full scan frames per blink half-period (legal >= 1).
REQ-004 SHALL have parameter OUTPUT_POLARITY, default 0, segment drive level: 0 = '0' lights, 1 = '1' lights.
REQ-005 SHALL have parameter DIGIT_POLARITY, default 0, digit-select level: 0 = '0' selects, 1 = '1' selects.
REQ-006 SHALL have port Clk, input, 1, single clock; all flops rising-edge.
REQ-007 SHALL have port nRst, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port Value, input, 4*NB_DIGITS, BCD nibbles; nibble i = digit i; digit 0 = least significant.
REQ-009 SHALL have port Load, input, 1, one-cycle strobe capturing Value into the shadow register.
REQ-010 SHALL have port Blank_lz, input, 1, leading-zero blanking enable.
REQ-011 SHALL have port Blink, input, 1, blink enable.
REQ-012 SHALL have port Seg, output, 7, segments a..g, Seg[6] = a, Seg[0] = g, registered.
REQ-013 SHALL have port Dig, output, NB_DIGITS, one-hot digit select, registered.

Function
REQ-014 SHALL capture Value into the shadow register on a rising edge with Load=1; otherwise hold.
REQ-015 SHALL run a prescaler 0..SCAN_DIV-1, wrapping to 0; tick = prescaler at SCAN_DIV-1.
REQ-016 SHALL advance digit index on tick: 0,1..NB_DIGITS-1, then 0; frame_end = tick with index NB_DIGITS-1.
REQ-017 SHALL count frame_end events 0..BLINK_DIV-1 and toggle blink phase on wrap.
REQ-018 SHALL decode active-high: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, 10..15=0110111 ('H').
REQ-019 SHALL blank digit i (i>0) when Blank_lz=1 and shadow nibbles i..NB_DIGITS-1 are all zero; digit 0 is never lz-blanked.
REQ-020 SHALL blank all digits while Blink=1 and blink phase=1; Blink=0 shows digits regardless of phase (phase keeps running).
REQ-021 SHALL drive, when current digit is shown: Seg = decoded pattern of shadow nibble at index, Dig = one-hot at index; when blanked: Seg all-off, Dig all-inactive.
REQ-022 SHALL apply polarity: Seg active-high pattern XOR ~OUTPUT_POLARITY per bit; Dig likewise with DIGIT_POLARITY.
REQ-023 SHALL register Seg/Dig every cycle from current index, shadow and phase: one-cycle latency from any state change to outputs.
REQ-024 SHALL, on Load coinciding with tick, use new shadow data and new index together at the following output update (no mixed frame).
REQ-025 SHALL, with NB_DIGITS=1, keep index at 0 and treat every tick as frame_end.
REQ-026 SHALL never assert more than one Dig bit active in any cycle, including around index wrap.

Reset
REQ-027 SHALL, while nRst=0, asynchronously force: shadow=0, prescaler=0, index=0, frame count=0, blink phase=0.
REQ-028 SHALL, while nRst=0, force Seg all-off and Dig all-inactive (polarity applied).
REQ-029 SHALL, on first rising edge after nRst release, output digit 0 of shadow (=0 -> pattern 1111110, polarity applied).
REQ-030 SHALL, on reset asserted mid-scan or mid-blink, abandon state immediately; no residual output after reset edge.

Verification (NB_DIGITS=4, SCAN_DIV=4, BLINK_DIV=2, polarities 0 unless stated)
REQ-031 SHALL cover: reset release, Load Value=0x1234 -> Dig cycles 1110,1101,1011,0111 every 4 clocks; Seg = ~pattern(4),~pattern(3),~pattern(2),~pattern(1).
REQ-032 SHALL cover: Value=0x0070, Blank_lz=1 -> digits 3,2 give Seg=1111111, Dig=1111; digit 1 shows '7' (0001111); digit 0 shows '0' (0000001).
REQ-033 SHALL cover: Blink=1 -> after 2 frames (32 clocks) all blanked for 32 clocks, then shown again; Blink=0 -> never blanked.
REQ-034 SHALL cover: nibble 0xA..0xF -> Seg=1001000 ('H' inverted); OUTPUT_POLARITY=1 and DIGIT_POLARITY=1 -> Seg=0110111, Dig one-hot high.
REQ-035 SHALL cover: Load coinciding with tick, then nRst pulsed low mid-frame -> next output uses new data and new index; during reset Seg=1111111, Dig=1111; after release digit 0 of shadow=0.
